test_result_reporter: RTL and testbench

- Sits directly downstream of the self-checking test modules, which each drive a done flag and a result flag (result high = failure).
- Latches per-test pass/fail and enforces a watchdog timeout.
- Emits a one-line ASCII verdict over an 8N1 serial TX pin, so board-level runs of the tests report without a simulator.

---
 rtl/test_result_reporter_pkg.sv | 26 ++
 rtl/test_result_reporter_uart_tx.sv | 74 +++++++
 rtl/test_result_reporter.sv | 149 ++++++++++++++
 tb/tb_test_result_reporter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/test_result_reporter_pkg.sv
// Shared definitions for the test result reporter and its serial transmitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package test_result_reporter_pkg;

  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    LOAD    = 2'd1,
    SEND    = 2'd2,
    FINISH  = 2'd3
  } state_t;

  localparam logic [7:0] CHAR_PASS    = 8'h50;  // 'P'
  localparam logic [7:0] CHAR_FAIL    = 8'h46;  // 'F'
  localparam logic [7:0] CHAR_TIMEOUT = 8'h54;  // 'T'
  localparam logic [7:0] CHAR_EOL     = 8'h0A;  // '\n'

  // Verdict character for one test: failure dominates, then completion,
  // otherwise the test never finished before the watchdog fired.
  function automatic logic [7:0] verdict_char(input logic failed, input logic done);
    if (failed)    return CHAR_FAIL;
    else if (done) return CHAR_PASS;
    else           return CHAR_TIMEOUT;
  endfunction

endpackage

// File: rtl/test_result_reporter_uart_tx.sv
// 8N1 serial transmitter for one byte per tx_start pulse.
// Latency: start bit drives tx_out the cycle after tx_start; frame lasts 10*CLKS_PER_BIT cycles.
// Backpressure: tx_start is ignored while tx_busy is high; caller must wait for tx_busy low.
// Ports: clk, rst_n (async active-low), tx_start (1-cycle pulse), tx_data[7:0],
//        tx_busy (high from start bit through end of stop bit), tx_out (idles high).
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_out
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [9:0]    shift_q, shift_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic          busy_q, busy_d;
  logic          out_q, out_d;

  always_comb begin
    shift_d   = shift_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    busy_d    = busy_q;
    out_d     = out_q;
    if (!busy_q) begin
      if (tx_start) begin
        // Frame is {stop, data, start}; bit 0 of the shifter is always on the wire.
        shift_d   = {1'b1, tx_data, 1'b0};
        out_d     = 1'b0;
        busy_d    = 1'b1;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    end else if (clk_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
      clk_cnt_d = '0;
      if (bit_cnt_q == 4'd9) begin
        busy_d = 1'b0;
        out_d  = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        shift_d   = {1'b1, shift_q[9:1]};
        out_d     = shift_q[1];
      end
    end else begin
      clk_cnt_d = clk_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '1;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      out_q     <= 1'b1;
    end else begin
      shift_q   <= shift_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      out_q     <= out_d;
    end
  end

  assign tx_busy = busy_q;
  assign tx_out  = out_q;

endmodule

// File: rtl/test_result_reporter.sv
// Latches per-test pass/fail, runs a watchdog, then reports one ASCII verdict line over 8N1 serial.
// Latency: masks update the cycle after inputs are sampled; report starts two cycles after all_done/timeout.
// Backpressure: none on inputs; the report FSM paces itself on the transmitter's busy flag.
// Ports: clk, rst_n (async active-low), test_done/test_result[N_TESTS] in;
//        fail_mask, done_mask, all_done, any_fail, timeout, uart_tx, report_done out.
module test_result_reporter
  import test_result_reporter_pkg::*;
#(
  parameter int N_TESTS        = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CLKS_PER_BIT   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_TESTS-1:0] test_done,
  input  logic [N_TESTS-1:0] test_result,
  output logic [N_TESTS-1:0] fail_mask,
  output logic [N_TESTS-1:0] done_mask,
  output logic               all_done,
  output logic               any_fail,
  output logic               timeout,
  output logic               uart_tx,
  output logic               report_done
);

  // idx runs 0..N_TESTS; the extra value selects the end-of-line byte.
  localparam int IW = (N_TESTS > 1) ? $clog2(N_TESTS + 1) : 1;

  state_t             state_q, state_d;
  logic [N_TESTS-1:0] fail_q, fail_d;
  logic [N_TESTS-1:0] done_q, done_d;
  logic               all_done_q, all_done_d;
  logic               any_fail_q, any_fail_d;
  logic               timeout_q, timeout_d;
  logic               report_done_q, report_done_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;

  logic       latch_en;
  logic       sel_fail, sel_done;
  logic       tx_start, tx_busy, tx_out;
  logic [7:0] tx_data;

  // Masks freeze as soon as a verdict exists, even while the FSM is still in MONITOR.
  assign latch_en = (state_q == MONITOR) && !all_done_q && !timeout_q;

  always_comb begin
    state_d       = state_q;
    fail_d        = fail_q;
    done_d        = done_q;
    all_done_d    = all_done_q;
    any_fail_d    = any_fail_q;
    timeout_d     = timeout_q;
    report_done_d = report_done_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    tx_start      = 1'b0;
    tx_data       = CHAR_EOL;
    sel_fail      = 1'b0;
    sel_done      = 1'b0;

    if (latch_en) begin
      // A result seen on the same cycle done rises still counts as a failure.
      fail_d     = fail_q | (~done_q & test_result);
      done_d     = done_q | test_done;
      all_done_d = &done_d;
      any_fail_d = |fail_d;
      cnt_d      = cnt_q + 32'd1;
      // Completion in the match cycle beats the watchdog.
      if (cnt_q == 32'(TIMEOUT_CYCLES - 1) && !all_done_d) timeout_d = 1'b1;
    end

    for (int i = 0; i < N_TESTS; i++) begin
      if (idx_q == IW'(i)) begin
        sel_fail = fail_q[i];
        sel_done = done_q[i];
      end
    end

    case (state_q)
      MONITOR: begin
        idx_d = '0;
        if (all_done_q || timeout_q) state_d = LOAD;
      end
      LOAD: begin
        tx_start = 1'b1;
        tx_data  = (idx_q == IW'(N_TESTS)) ? CHAR_EOL : verdict_char(sel_fail, sel_done);
        state_d  = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          if (idx_q < IW'(N_TESTS)) begin
            idx_d   = idx_q + 1'b1;
            state_d = LOAD;
          end else begin
            report_done_d = 1'b1;
            state_d       = FINISH;
          end
        end
      end
      FINISH:  state_d = FINISH;
      default: state_d = MONITOR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= MONITOR;
      fail_q        <= '0;
      done_q        <= '0;
      all_done_q    <= 1'b0;
      any_fail_q    <= 1'b0;
      timeout_q     <= 1'b0;
      report_done_q <= 1'b0;
      cnt_q         <= '0;
      idx_q         <= '0;
    end else begin
      state_q       <= state_d;
      fail_q        <= fail_d;
      done_q        <= done_d;
      all_done_q    <= all_done_d;
      any_fail_q    <= any_fail_d;
      timeout_q     <= timeout_d;
      report_done_q <= report_done_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_busy (tx_busy),
    .tx_out  (tx_out)
  );

  assign fail_mask   = fail_q;
  assign done_mask   = done_q;
  assign all_done    = all_done_q;
  assign any_fail    = any_fail_q;
  assign timeout     = timeout_q;
  assign uart_tx     = tx_out;
  assign report_done = report_done_q;

endmodule

// File: tb/tb_test_result_reporter.sv
// Self-checking bench: scenario table plus random scenarios, reference model of the
// verdict rules, and a serial receiver that decodes and shape-checks every frame.
module tb_test_result_reporter;

  localparam int N   = 4;
  localparam int TO  = 50;
  localparam int CPB = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] test_done = '0;
  logic [N-1:0] test_result = '0;
  logic [N-1:0] fail_mask, done_mask;
  logic         all_done, any_fail, timeout, uart_tx, report_done;

  test_result_reporter #(
    .N_TESTS(N), .TIMEOUT_CYCLES(TO), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .test_done(test_done), .test_result(test_result),
    .fail_mask(fail_mask), .done_mask(done_mask), .all_done(all_done),
    .any_fail(any_fail), .timeout(timeout), .uart_tx(uart_tx), .report_done(report_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: what each test has done so far and the resulting verdicts.
  bit m_done[N];
  bit m_fail[N];
  bit m_all, m_any, m_to, m_mon;
  int m_k;

  // Scenario description: per-test done cycle (-1 never), one-cycle pulse or held,
  // and a window of result=1.
  int done_at[N];
  bit done_pulse[N];
  int fail_at[N];
  int fail_len[N];

  // Serial receiver state.
  bit         rx_active;
  int         rx_cyc;
  logic [7:0] rx_byte;
  logic       rx_cur;
  bit         rx_ok;
  logic [7:0] rx_q[$];
  int         last_end;
  int         since_rel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, since_rel);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_done[i] = 1'b0;
      m_fail[i] = 1'b0;
    end
    m_all = 0; m_any = 0; m_to = 0; m_mon = 1; m_k = 0;
  endtask

  task automatic model_step(input logic [N-1:0] d, input logic [N-1:0] r);
    if (m_mon) begin
      if (m_all || m_to) begin
        m_mon = 0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (!m_done[i] && r[i]) m_fail[i] = 1'b1;
          if (d[i]) m_done[i] = 1'b1;
        end
        m_all = 1;
        m_any = 0;
        for (int i = 0; i < N; i++) begin
          m_all = m_all & m_done[i];
          m_any = m_any | m_fail[i];
        end
        if (m_k == TO - 1 && !m_all) m_to = 1;
        m_k++;
      end
    end
  endtask

  function automatic logic [N-1:0] pack(input bit a[N]);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = a[i];
    return v;
  endfunction

  function automatic logic [7:0] exp_byte(input int i);
    if (i == N)        return 8'h0A;
    else if (m_fail[i]) return 8'h46;
    else if (m_done[i]) return 8'h50;
    else               return 8'h54;
  endfunction

  task automatic rx_clear();
    rx_active = 0; rx_cyc = 0; rx_byte = '0; rx_cur = 1'b1; rx_ok = 1;
    rx_q.delete();
    last_end = 0;
  endtask

  // Called once per cycle at the falling clock edge.
  task automatic rx_step();
    int bit_i, phase, gap;
    if (!rx_active && uart_tx === 1'b0) begin
      rx_active = 1; rx_cyc = 0; rx_ok = 1; rx_byte = '0;
      if (rx_q.size() > 0) begin
        gap = since_rel - last_end - 1;
        chk("frame_gap_1_or_2", 32'(gap >= 1 && gap <= 2), 32'd1);
      end
    end
    if (rx_active) begin
      bit_i = rx_cyc / CPB;
      phase = rx_cyc % CPB;
      if (phase == 0) begin
        rx_cur = uart_tx;
        if (bit_i == 0 && rx_cur !== 1'b0) rx_ok = 0;
        if (bit_i >= 1 && bit_i <= 8) rx_byte[bit_i-1] = rx_cur;
        if (bit_i == 9 && rx_cur !== 1'b1) rx_ok = 0;
      end else if (uart_tx !== rx_cur) begin
        rx_ok = 0;
      end
      if (rx_cyc == 10 * CPB - 1) begin
        chk("frame_shape", 32'(rx_ok), 32'd1);
        rx_q.push_back(rx_byte);
        rx_active = 0;
        last_end = since_rel;
      end else begin
        rx_cyc++;
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    test_done = '0;
    test_result = '0;
    repeat (2) @(negedge clk);
    chk("rst_fail_mask", 32'(fail_mask), 32'd0);
    chk("rst_done_mask", 32'(done_mask), 32'd0);
    chk("rst_flags", {28'd0, all_done, any_fail, timeout, report_done}, 32'd0);
    chk("rst_uart_tx", 32'(uart_tx), 32'd1);
    rst_n = 1'b1;
    model_reset();
    rx_clear();
    since_rel = 0;
  endtask

  task automatic clear_scn();
    for (int i = 0; i < N; i++) begin
      done_at[i] = -1; done_pulse[i] = 0; fail_at[i] = -1; fail_len[i] = 0;
    end
  endtask

  // lit: expected report text ("" = model only); exp_all/exp_to: first cycle the flag
  // is visible (-1 never, -2 unchecked); exp_fail: final fail_mask (-1 unchecked).
  task automatic run(input string name, input string lit, input bit abort_third,
                     input int exp_all, input int exp_to, input int exp_fail);
    int  first_all, first_to, budget;
    bit  finished, aborted;
    logic [N-1:0] d, r;
    first_all = -1; first_to = -1; finished = 0; aborted = 0; budget = 0;
    apply_reset();
    while (!finished && budget < 1500) begin
      budget++;
      if (m_mon && !m_all && !m_to) begin
        for (int i = 0; i < N; i++) begin
          d[i] = (done_at[i] >= 0) && (m_k >= done_at[i]) && (!done_pulse[i] || m_k == done_at[i]);
          r[i] = (fail_at[i] >= 0) && (m_k >= fail_at[i]) && (m_k < fail_at[i] + fail_len[i]);
        end
      end else begin
        d = N'($urandom);
        r = N'($urandom);
      end
      test_done = d;
      test_result = r;
      model_step(d, r);
      @(negedge clk);
      since_rel++;

      chk("fail_mask", 32'(fail_mask), 32'(pack(m_fail)));
      chk("done_mask", 32'(done_mask), 32'(pack(m_done)));
      chk("all_done", 32'(all_done), 32'(m_all));
      chk("any_fail", 32'(any_fail), 32'(m_any));
      chk("timeout", 32'(timeout), 32'(m_to));
      if (m_mon) chk("tx_idle_in_monitor", 32'(uart_tx), 32'd1);
      if (all_done && first_all < 0) first_all = since_rel;
      if (timeout && first_to < 0) first_to = since_rel;

      rx_step();
      if (rx_q.size() < N + 1) chk("report_done_early", 32'(report_done), 32'd0);

      if (abort_third && !aborted && rx_q.size() == 2 && rx_active && rx_cyc == 3 * CPB) begin
        aborted = 1;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_uart_tx", 32'(uart_tx), 32'd1);
        chk("abort_masks", {fail_mask, done_mask}, 32'd0);
        chk("abort_flags", {28'd0, all_done, any_fail, timeout, report_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        rx_clear();
        since_rel = 0;
        first_all = -1;
        first_to = -1;
      end else if (report_done) begin
        finished = 1;
        chk("report_done_latency", 32'(since_rel - last_end >= 1 && since_rel - last_end <= 4), 32'd1);
      end
    end
    chk({name, "_finished"}, 32'(finished), 32'd1);
    // Line must stay idle after the report.
    repeat (3) begin
      @(negedge clk);
      chk("tx_idle_after", 32'(uart_tx), 32'd1);
    end
    chk({name, "_nbytes"}, 32'(rx_q.size()), 32'(N + 1));
    for (int i = 0; i < N + 1 && i < rx_q.size(); i++) begin
      chk({name, "_byte_model"}, 32'(rx_q[i]), 32'(exp_byte(i)));
      if (lit.len() == N + 1) chk({name, "_byte_lit"}, 32'(rx_q[i]), 32'(lit[i]));
    end
    if (exp_all != -2) chk({name, "_all_done_cycle"}, 32'(first_all), 32'(exp_all));
    if (exp_to != -2) chk({name, "_timeout_cycle"}, 32'(first_to), 32'(exp_to));
    if (exp_fail >= 0) chk({name, "_fail_mask_final"}, 32'(fail_mask), 32'(exp_fail));
  endtask

  initial begin
    since_rel = 0;
    model_reset();
    rx_clear();

    // All pass in order.
    clear_scn();
    done_at[0] = 10; done_at[1] = 20; done_at[2] = 30; done_at[3] = 40;
    run("all_pass", "PPPP\n", 0, 41, -1, 0);

    // Test 2 fails with a one-cycle result pulse long before its done.
    clear_scn();
    done_at[0] = 10; done_at[1] = 20; done_at[2] = 30; done_at[3] = 40;
    fail_at[2] = 15; fail_len[2] = 1;
    run("fail_pulse", "PPFP\n", 0, 41, -1, 4'b0100);

    // Tests 2 and 3 never finish: watchdog matches at counter 49, flag visible at 50.
    clear_scn();
    done_at[0] = 10; done_at[1] = 20;
    run("watchdog", "PPTT\n", 0, -1, 50, 0);

    // Last done lands on the watchdog match cycle: completion wins.
    clear_scn();
    done_at[0] = 10; done_at[1] = 20; done_at[2] = 30; done_at[3] = TO - 1;
    run("tie", "PPPP\n", 0, TO, -1, 0);

    // Result after done is ignored; a done pulse still latches.
    clear_scn();
    done_at[1] = 10; done_pulse[1] = 1; fail_at[1] = 11; fail_len[1] = 5;
    done_at[3] = 12; done_pulse[3] = 1;
    done_at[0] = 20; done_at[2] = 25;
    run("post_done", "PPPP\n", 0, 26, -1, 0);

    // Failure sampled on the same cycle done rises is still a failure.
    clear_scn();
    done_at[0] = 5; done_at[1] = 6; done_at[2] = 7; done_at[3] = 8;
    fail_at[0] = 5; fail_len[0] = 1;
    run("fail_on_done", "FPPP\n", 0, 9, -1, 4'b0001);

    // Reset in the third frame's data bits, then a clean full report.
    clear_scn();
    done_at[0] = 10; done_at[1] = 20; done_at[2] = 30; done_at[3] = 40;
    run("abort", "PPPP\n", 1, 41, -1, 0);

    // Random scenarios checked against the model only.
    for (int s = 0; s < 6; s++) begin
      clear_scn();
      for (int i = 0; i < N; i++) begin
        done_at[i]    = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 55));
        done_pulse[i] = 1'($urandom_range(0, 1));
        fail_at[i]    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 55)) : -1;
        fail_len[i]   = int'($urandom_range(1, 6));
      end
      run("random", "", 0, -2, -2, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
